// File: rtl/div_ctrl.sv
// div_ctrl -- multi-cycle 32-bit integer divider controller (DIV / DIVU).
//
// A request held on start_i is accepted in IDLE, then a restoring radix-2
// divider retires one quotient bit per clock for 32 clocks. The result is
// {remainder, quotient} and is held on result_o until the next load. ready_o
// stays high in DIV_END for as long as the requester keeps start_i high.
//
// Optional feature: define DIV_EARLY_ZERO_EN to short-circuit a zero divisor
// through the BYZERO state (result 64'h0 two edges after accept). With the
// macro undefined, a zero divisor runs the full 32 steps and returns
// {latched dividend, 32'hFFFFFFFF}.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        annul_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE    = 2'd0;
`ifdef DIV_EARLY_ZERO_EN
  localparam logic [1:0] BYZERO  = 2'd1;
`endif
  localparam logic [1:0] DIV_ON  = 2'd2;
  localparam logic [1:0] DIV_END = 2'd3;

  localparam logic [5:0] LAST_STEP = 6'd31;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_op1;      // dividend as presented (raw bits)
  logic [31:0] r_op2;      // divisor as presented (raw bits)
  logic        r_signed;
  logic [31:0] r_rem;      // partial remainder
  logic [31:0] r_quo;      // dividend magnitude shifting out / quotient in
  logic [31:0] r_dvs;      // divisor magnitude
  logic [63:0] r_result;
  logic        r_ready;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_step;
  logic        w_finish;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_fits;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic        w_q_neg;
  logic        w_r_neg;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [63:0] w_final;

  // Request handshake qualifiers. annul_i beats start_i everywhere.
  assign w_accept = (r_state == IDLE) && start_i && !annul_i;
  assign w_step   = (r_state == DIV_ON) && !annul_i;
  assign w_finish = w_step && (r_cnt == LAST_STEP);

  // Magnitudes taken from the live inputs at the accept edge. Two's-complement
  // negation of 0x80000000 wraps to 0x80000000, which is the correct unsigned
  // magnitude, so no special case is needed.
  assign w_op1_mag = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_mag = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step: bring the next dividend bit into the remainder and try
  // to subtract the divisor. The extra top bit of w_diff is the borrow.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_fits    = ~w_diff[33];
  assign w_rem_nxt = w_fits ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fits};

  // Sign correction: quotient is negative when the operand signs differ,
  // remainder follows the dividend.
  assign w_q_neg   = r_signed && (r_op1[31] ^ r_op2[31]);
  assign w_r_neg   = r_signed && r_op1[31];
  assign w_quo_fix = w_q_neg ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
  assign w_rem_fix = w_r_neg ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

`ifdef DIV_EARLY_ZERO_EN
  // Zero divisors never reach DIV_ON in this build.
  assign w_final = {w_rem_fix, w_quo_fix};
`else
  // A zero divisor runs the full loop; report the raw dividend and an
  // all-ones quotient without any sign correction.
  assign w_final = (r_op2 == 32'd0) ? {r_op1, 32'hFFFF_FFFF}
                                    : {w_rem_fix, w_quo_fix};
`endif

  // Next-state decode for the control FSM.
  always_comb begin
    // NOTE: default assignment first so every path drives w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
`ifdef DIV_EARLY_ZERO_EN
            w_state_nxt = (opdata2_i == 32'd0) ? BYZERO : DIV_ON;
`else
            w_state_nxt = DIV_ON;
`endif
          end
        end
`ifdef DIV_EARLY_ZERO_EN
        BYZERO:  w_state_nxt = DIV_END;
`endif
        DIV_ON: begin
          if (r_cnt == LAST_STEP) w_state_nxt = DIV_END;
        end
        DIV_END: begin
          if (!start_i) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register and step counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= 6'd0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  // Operand capture at accept and one shift/subtract per DIV_ON cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_signed <= 1'b0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
    end else if (w_accept) begin
      r_op1    <= opdata1_i;
      r_op2    <= opdata2_i;
      r_signed <= signed_i;
      r_rem    <= 32'd0;
      r_quo    <= w_op1_mag;
      r_dvs    <= w_op2_mag;
    end else if (w_step) begin
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
    end
  end

  // Result load and ready flag; the result only changes when a divide completes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else if (annul_i) begin
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
`ifdef DIV_EARLY_ZERO_EN
        BYZERO: begin
          r_result <= 64'd0;
          r_ready  <= 1'b1;
        end
`endif
        DIV_ON: begin
          if (w_finish) begin
            r_result <= w_final;
            r_ready  <= 1'b1;
          end
        end
        DIV_END: begin
          if (!start_i) r_ready <= 1'b0;
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign stall_o  = start_i & ~r_ready;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port resetn, input, 1 bit, a synchronous active-low reset sampled on the clk rising edge.
REQ-003 The block SHALL have the port start_i, input, 1 bit, the divide request; it is held high by the pipeline until ready_o is seen.
REQ-004 The block SHALL have the port signed_i, input, 1 bit: 1 selects DIV (two's complement), 0 selects DIVU.
REQ-005 The block SHALL have the port annul_i, input, 1 bit, a flush/exception cancel.
REQ-006 The block SHALL have the port opdata1_i, input, 32 bits, the dividend (rs).
REQ-007 The block SHALL have the port opdata2_i, input, 32 bits, the divisor (rt).
REQ-008 The block SHALL have the port result_o, output, 64 bits, {remainder→HI[63:32], quotient→LO[31:0]}.
REQ-009 The block SHALL have the port ready_o, output, 1 bit, result valid.
REQ-010 The block SHALL have the port stall_o, output, 1 bit, the pipeline stall request to the hazard unit.

Function
REQ-011 The FSM SHALL have the states IDLE, BYZERO, DIV_ON and DIV_END, all registered.
REQ-012 In IDLE with start_i=1 and annul_i=0, the block SHALL latch both operands and signed_i; later operand changes are ignored until the next IDLE.
REQ-013 At that accept edge, if signed_i=1 the block SHALL store the magnitudes |op1| and |op2|; 0x80000000 maps to magnitude 0x80000000.
REQ-014 From IDLE, a divisor ≠ 0 SHALL go to DIV_ON with a 6-bit counter cleared to 0; divisor = 0 SHALL follow REQ-028/029.
REQ-015 DIV_ON SHALL perform a restoring radix-2 step each cycle: shift the 33-bit partial remainder left by one, subtract the divisor, and set the quotient bit to 1 if the difference is ≥0 (keeping it), else 0 (restoring).
REQ-016 After exactly 32 DIV_ON cycles (counter==31 on the step edge) the FSM SHALL go to DIV_END.
REQ-017 On entry to DIV_END, result_o SHALL be loaded and ready_o asserted; latency is exactly 33 clk edges from the accepting edge to ready_o=1.
REQ-018 Sign fix for signed divides: the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-019 The signed case 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-020 The FSM SHALL stay in DIV_END with ready_o=1 while start_i=1, and go to IDLE (ready_o=0) on the first edge with start_i=0.
REQ-021 stall_o SHALL equal (start_i & ~ready_o) combinationally, so it is high during the accept cycle, BYZERO and DIV_ON, and low in DIV_END.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge with ready_o=0 and result_o unchanged; annul_i has priority over start_i.
REQ-023 result_o SHALL hold its last loaded value outside DIV_END.
REQ-024 A new start_i seen in DIV_END SHALL NOT restart the divide; a back-to-back divide needs one IDLE cycle.

Reset
REQ-025 With resetn=0 at a clk edge: state←IDLE, counter←0, result_o←64'h0, ready_o←0, operand registers←0.
REQ-026 Reset SHALL abort any divide in progress with no partial result visible; stall_o follows REQ-021 using the reset ready_o=0.
REQ-027 Reset SHALL take priority over annul_i and start_i.

Configuration
REQ-028 With macro DIV_EARLY_ZERO_EN defined, a zero divisor SHALL route IDLE→BYZERO→DIV_END, giving result_o=64'h0 and ready_o at the 2nd edge after accept.
REQ-029 Without DIV_EARLY_ZERO_EN, a zero divisor SHALL run all 32 DIV_ON cycles and produce exactly result_o={latched opdata1_i, 32'hFFFFFFFF}, with no sign fix and ready_o at edge 33; the BYZERO state is absent.

Verification
REQ-030 Unsigned 100/7, start held -> ready_o at edge 33, result_o={32'd2, 32'd14}, and stall_o high for edges 0..32.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x1, 0xFFFFFFFD}.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> {0x0, 0x80000000}; unsigned 0xFFFFFFFF/0x1 -> {0x0, 0xFFFFFFFF}.
REQ-033 Divide 5/0 -> with the macro, result_o=0 at edge 2; without it, result_o={0x5, 0xFFFFFFFF} at edge 33.
REQ-034 annul_i pulsed at DIV_ON counter 10 -> IDLE next edge, ready_o stays 0, result_o keeps its prior value, and a subsequent 9/3 returns {0, 3}.
REQ-035 resetn=0 for one edge mid-divide (counter 20) -> all outputs are reset values the next cycle; ready_o never asserts for the aborted divide.
